// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - fetch, memory and data-array signals of the icache refill controller
//
// Purpose: bundles every non-clock/reset signal of icache_refill_ctrl.
//   slave  : the refill controller (sees fetch/memory inputs, drives hit/stall/mem/fill)
//   master : the surrounding fetch stage, memory port and data array
// Signals:
//   fetch_valid, fetch_addr  fetch request, word address {tag, index, offset}
//   hit, stall               lookup result / hold-and-retry request to fetch
//   flush                    invalidate all lines
//   mem_req, mem_addr        line read request, line base address
//   mem_ack                  request accepted
//   mem_rvalid, mem_rdata    refill word stream
//   fill_we, fill_addr       data-array write strobe, {index, word}
//   fill_data                data-array write data
interface icache_refill_ctrl_if #(
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
);
  logic                        fetch_valid;
  logic [ADDR_W-1:0]           fetch_addr;
  logic                        hit;
  logic                        stall;
  logic                        flush;
  logic                        mem_req;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_ack;
  logic                        mem_rvalid;
  logic [31:0]                 mem_rdata;
  logic                        fill_we;
  logic [INDEX_W+OFFSET_W-1:0] fill_addr;
  logic [31:0]                 fill_data;

  modport slave (
    input  fetch_valid, fetch_addr, flush, mem_ack, mem_rvalid, mem_rdata,
    output hit, stall, mem_req, mem_addr, fill_we, fill_addr, fill_data
  );

  modport master (
    output fetch_valid, fetch_addr, flush, mem_ack, mem_rvalid, mem_rdata,
    input  hit, stall, mem_req, mem_addr, fill_we, fill_addr, fill_data
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - direct-mapped icache tag/valid array and line refill controller
//
// Purpose: holds the tag/valid array, looks up every fetch address, stalls fetch
// on a miss, requests the missing line from memory and streams the returned
// burst into the data array. flush invalidates every line.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset (state, valid bits, counters; tags are kept)
//   bus  icache_refill_ctrl_if.slave:
//     fetch_valid/fetch_addr in, hit/stall out (combinational)
//     flush in
//     mem_req/mem_addr out (registered), mem_ack/mem_rvalid/mem_rdata in
//     fill_we/fill_addr/fill_data out (combinational from the refill stream)
module icache_refill_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_refill_ctrl_if.slave  bus
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [LINES];
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [OFFSET_W-1:0]  cnt_q, cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 tag_we;

  logic [TAG_W-1:0]     f_tag;
  logic [INDEX_W-1:0]   f_idx;
  logic                 match;
  logic                 is_idle;
  logic                 miss;
  logic                 word_fire;
  logic                 last_word;

  // Lookup against the fetch address; only meaningful in IDLE because after
  // that the controller works purely from the latched miss registers.
  assign f_tag     = bus.fetch_addr[ADDR_W-1 -: TAG_W];
  assign f_idx     = bus.fetch_addr[OFFSET_W +: INDEX_W];
  assign match     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign is_idle   = (state_q == IDLE);
  assign miss      = bus.fetch_valid && is_idle && !match;

  assign bus.hit   = bus.fetch_valid && is_idle && match;
  assign bus.stall = miss || !is_idle;

  // Refill words go straight through to the data array in the cycle they arrive.
  assign word_fire     = (state_q == FILL) && bus.mem_rvalid;
  assign last_word     = word_fire && (cnt_q == LAST_WORD);
  assign bus.fill_we   = word_fire;
  assign bus.fill_addr = word_fire ? {miss_idx_q, cnt_q} : '0;
  assign bus.fill_data = bus.mem_rdata;

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    tag_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss) begin
          miss_tag_d   = f_tag;
          miss_idx_d   = f_idx;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
          mem_req_d    = 1'b1;
          mem_addr_d   = {f_tag, f_idx, {OFFSET_W{1'b0}}};
          state_d      = REQ;
        end
      end
      REQ: begin
        // The burst cannot be aborted, so a flush here only prevents validation.
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_rvalid) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          if (cnt_q == LAST_WORD) begin
            tag_we  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush on the last word wins: the clear happens and the set is suppressed.
    if (bus.flush) valid_d = '0;
    if (last_word && !bus.flush && !flush_pend_q) valid_d[miss_idx_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[miss_idx_q] <= miss_tag_q;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Refill controller for the direct-mapped instruction cache that sits between the fetch stage and the core's memory port. It holds the tag/valid array, checks each fetch address for a hit, and stalls fetch on a miss. During the stall it fetches the missing line from memory as a fixed-length burst and writes each word into the cache data array. It also provides a global invalidate (flush) for self-modifying code and reset-time initialisation.

## Interface
- ADDR_W, 16, width of the word address (matches the PC width)
- INDEX_W, 4, line-index bits (2^INDEX_W lines)
- OFFSET_W, 2, word-in-line bits (2^OFFSET_W words per line)
- TAG_W, ADDR_W-INDEX_W-OFFSET_W, tag bits (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_valid  in  1  fetch stage presents an address this cycle
- fetch_addr  in  ADDR_W  word address {tag, index, offset}
- hit  out  1  fetch_addr is resident; data array output is valid
- stall  out  1  fetch must hold fetch_addr and retry
- flush  in  1  invalidate all lines
- mem_req  out  1  line read request
- mem_addr  out  ADDR_W  line base address {tag, index, OFFSET_W'b0}
- mem_ack  in  1  request accepted
- mem_rvalid  in  1  one refill word on mem_rdata
- mem_rdata  in  32  refill word
- fill_we  out  1  data-array write strobe
- fill_addr  out  INDEX_W+OFFSET_W  data-array write address {index, word}
- fill_data  out  32  data-array write data

## Operation
- Internal storage: valid[2^INDEX_W] bits and tag[2^INDEX_W] × TAG_W registers.
- match = valid[idx] && tag[idx] == fetch_addr tag field.
- hit = fetch_valid && state==IDLE && match.
- stall = (fetch_valid && !match && state==IDLE) || state!=IDLE.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE: if fetch_valid && !match, latch the tag and index into miss registers, clear word counter and flush_pend, and go to REQ.
  - REQ: mem_req=1 and mem_addr={miss_tag, miss_idx, 0}, both held stable until mem_ack is sampled high. Then go to FILL.
  - FILL: on each mem_rvalid, drive fill_we=1, fill_addr={miss_idx, cnt} and fill_data=mem_rdata (combinational), then increment cnt. When the word with cnt==2^OFFSET_W-1 is received: write tag[miss_idx]=miss_tag, set valid[miss_idx]=!flush_pend && !flush, and go to DONE.
  - DONE: one cycle with stall=1. Then go to IDLE.
- fetch_addr must stay stable while stall=1. The controller uses only the latched miss registers after IDLE.
- Outside FILL, mem_rvalid is ignored and fill_we=0. mem_ack outside REQ is ignored.
- Flush:
  - In any state, flush clears every valid bit at the clock edge.
  - In REQ or FILL, flush also sets flush_pend. The burst still completes, because memory cannot abort it, but the line is not validated.
  - If flush coincides with the last refill word, flush wins and the line stays invalid.
  - In IDLE, a flush cycle still evaluates match against the pre-flush valid bits. The next cycle misses.
- Async rst: state=IDLE, all valid=0, cnt=0, flush_pend=0. Tags are left as-is (don't-care).

## Timing
- Reset values: hit=0, stall=0 (both remain 0 until fetch_valid is asserted), mem_req=0, mem_addr=0, fill_we=0, fill_addr=0, fill_data=mem_rdata passthrough (don't-care while fill_we=0).
- Hit: zero-latency and combinational, in the same cycle as fetch_valid.
- Miss detected in cycle T: stall=1 in T, and mem_req rises in T+1.
- If ack is sampled in cycle A, FILL starts at A+1. Memory must not return rvalid before A+1.
- Each word is written in the cycle its rvalid arrives. Gaps between words are allowed, and stall holds through them.
- Last word in cycle L: DONE at L+1, IDLE at L+2, and the retried fetch hits at L+2.
- Minimum miss penalty (ack at T+1, 4 back-to-back words at T+2..T+5): stall spans T..T+6, hit at T+7.
- Reset asserted mid-refill aborts immediately. Words still in flight from memory are ignored afterwards.

## Test plan
- Reset, then fetch 0x0040 → stall=1 with no hit; mem_req at T+1 with mem_addr=0x0040; ack at T+1; words 0xA0..0xA3 at T+2..T+5 → fill_addr 0x0..0x3 with matching data; hit=1 at T+7 and stall=0.
- Refill index 0 at tag 1 (0x0040), then fetch 0x0080 (same index, tag 2) → miss, refill, and tag replaced; a subsequent fetch of 0x0040 misses again.
- Ack delayed 5 cycles and rvalid with 2-cycle gaps → mem_req/mem_addr are stable until ack, exactly 4 fill_we pulses occur, and stall is continuous until DONE+1.
- Flush asserted during FILL, on word 2 → burst still written, valid[idx]=0 at end, and the retried fetch misses and refills again; flush coincident with the last word gives the same result.
- rst pulsed in FILL after word 1 → outputs 0 immediately; further rvalid produces no fill_we; fetch of the same address afterwards misses.
- Flush in IDLE with lines 0..15 all valid → every subsequent fetch misses, with exactly one mem_req per miss.
